// File: rtl/clk_step_pkg.sv
// Shared types, widths and arithmetic helpers for the clock-step controller.
package clk_step_pkg;

  // Width of the cumulative gated-cycle total.
  localparam int unsigned TOTAL_W = 48;
  // Width of one step request (K).
  localparam int unsigned CMD_W   = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT_RUN = 3'd2,
    RUN      = 3'd3,
    RELEASE  = 3'd4
  } step_ctrl_state_e;

  typedef struct packed {
    logic [CMD_W-1:0] cycles;
  } step_cmd_t;

  // Adds a step length to the running total, clamping at the all-ones value.
  function automatic logic [TOTAL_W-1:0] sat_add_total(input logic [TOTAL_W-1:0] acc,
                                                       input logic [CMD_W:0]     inc);
    logic [TOTAL_W:0] sum;
    sum = {1'b0, acc} + {{(TOTAL_W - CMD_W){1'b0}}, inc};
    if (sum[TOTAL_W]) begin
      return {TOTAL_W{1'b1}};
    end else begin
      return sum[TOTAL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/clk_step_cmd_fifo.sv
// Synchronous first-word-fall-through command buffer with flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module clk_step_cmd_fifo
  import clk_step_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W:0]   wptr_r;
  logic [PTR_W:0]   rptr_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_s   = (wptr_r == rptr_r);
  assign full_s    = (wptr_r[PTR_W] != rptr_r[PTR_W]) &&
                     (wptr_r[PTR_W-1:0] == rptr_r[PTR_W-1:0]);
  assign push_ok_s = push_i && !full_s;
  assign pop_ok_s  = pop_i && !empty_s;

  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign rdata_o = mem_r[rptr_r[PTR_W-1:0]];

  // Pointer update; a flush discards every entry and wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else if (flush_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + {{PTR_W{1'b0}}, 1'b1};
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + {{PTR_W{1'b0}}, 1'b1};
      end else begin
        rptr_r <= rptr_r;
      end
    end
  end

  // Storage array; written only on an accepted, non-flushed push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s && !flush_i) begin
      mem_r[wptr_r[PTR_W-1:0]] <= wdata_i;
    end else begin
      mem_r <= mem_r;
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Command-driven initiator for the clock stepping unit: buffers "run K cycles"
// requests, sequences en/start towards the stepper, detects completion or a
// missing start, and keeps done/cycle statistics.
module clk_step_ctrl
  import clk_step_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned START_TIMEOUT = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [31:0]        cmd_cycles_i,
  input  logic               abort_i,
  output logic               step_en_o,
  output logic [31:0]        step_cycles_o,
  output logic               step_start_o,
  input  logic               step_running_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   steps_done_o,
  output logic [TOTAL_W-1:0] total_cycles_o
);

  localparam int unsigned TO_W = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT);

  step_ctrl_state_e state_r, state_s;

  step_cmd_t        push_cmd_s;
  step_cmd_t        head_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;

  logic               step_en_r,     step_en_s;
  logic               step_start_r,  step_start_s;
  logic [31:0]        step_cycles_r, step_cycles_s;
  logic               done_r,        done_s;
  logic               err_r,         err_s;
  logic [CNT_W-1:0]   steps_done_r,  steps_done_s;
  logic [TOTAL_W-1:0] total_r,       total_s;
  logic [TO_W-1:0]    to_cnt_r,      to_cnt_s;

  // New commands are refused while full and while abort is held.
  assign cmd_ready_o = !full_s && !abort_i;
  assign push_s      = cmd_valid_i && cmd_ready_o;
  assign push_cmd_s  = '{cycles: cmd_cycles_i};
  assign busy_o      = (state_r != IDLE) || !empty_s;

  clk_step_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(step_cmd_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (abort_i),
    .push_i  (push_s),
    .wdata_i (push_cmd_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Next-state and next-output logic; outputs describe the state being entered.
  always_comb begin
    state_s       = state_r;
    pop_s         = 1'b0;
    step_en_s     = 1'b0;
    step_start_s  = 1'b0;
    step_cycles_s = step_cycles_r;
    done_s        = 1'b0;
    err_s         = err_r;
    steps_done_s  = steps_done_r;
    total_s       = total_r;
    to_cnt_s      = to_cnt_r;
    case (state_r)
      IDLE: begin
        if (abort_i) begin
          state_s = IDLE;
        end else if (!empty_s) begin
          pop_s = 1'b1;
          if (head_s.cycles == 32'd0) begin
            // Zero-length step completes without touching the stepper.
            done_s       = 1'b1;
            steps_done_s = steps_done_r + CNT_W'(1'b1);
          end else begin
            // The stepper gates N+1 cycles, so program K-1.
            step_cycles_s = head_s.cycles - 32'd1;
            err_s         = 1'b0;
            state_s       = ARM;
            step_en_s     = 1'b1;
            step_start_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ARM: begin
        if (abort_i) begin
          state_s = RELEASE;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else begin
          state_s   = WAIT_RUN;
          step_en_s = 1'b1;
          to_cnt_s  = '0;
        end
      end
      WAIT_RUN: begin
        if (abort_i) begin
          state_s = RELEASE;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else if (step_running_i) begin
          state_s   = RUN;
          step_en_s = 1'b1;
        end else if (to_cnt_r == TO_LAST) begin
          state_s = RELEASE;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else begin
          step_en_s = 1'b1;
          to_cnt_s  = to_cnt_r + TO_W'(1'b1);
        end
      end
      RUN: begin
        if (abort_i) begin
          state_s = RELEASE;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else if (!step_running_i) begin
          state_s      = RELEASE;
          done_s       = 1'b1;
          steps_done_s = steps_done_r + CNT_W'(1'b1);
          total_s      = sat_add_total(total_r, {1'b0, step_cycles_r} + 33'd1);
        end else begin
          step_en_s = 1'b1;
        end
      end
      RELEASE: begin
        // en stays low for this cycle to release the parked stepper.
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= IDLE;
      step_en_r     <= 1'b0;
      step_start_r  <= 1'b0;
      step_cycles_r <= 32'd0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      steps_done_r  <= '0;
      total_r       <= '0;
      to_cnt_r      <= '0;
    end else begin
      state_r       <= state_s;
      step_en_r     <= step_en_s;
      step_start_r  <= step_start_s;
      step_cycles_r <= step_cycles_s;
      done_r        <= done_s;
      err_r         <= err_s;
      steps_done_r  <= steps_done_s;
      total_r       <= total_s;
      to_cnt_r      <= to_cnt_s;
    end
  end

  assign step_en_o      = step_en_r;
  assign step_start_o   = step_start_r;
  assign step_cycles_o  = step_cycles_r;
  assign done_o         = done_r;
  assign err_o          = err_r;
  assign steps_done_o   = steps_done_r;
  assign total_cycles_o = total_r;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: a behavioural stepping unit drives the main
// instance; a second instance with a stepper that never starts covers the
// start timeout and a narrow counter for wrap-around.
module tb_clk_step_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance signals
  logic        cmd_valid, cmd_ready, abort, step_en, step_start, busy, done, err;
  logic [31:0] cmd_cycles, step_cycles;
  logic [15:0] steps_done;
  logic [47:0] total;
  // Second instance signals
  logic        cmd_valid2, cmd_ready2, abort2, step_en2, step_start2, busy2, done2, err2;
  logic [31:0] cmd_cycles2, step_cycles2;
  logic [2:0]  steps_done2;
  logic [47:0] total2;

  // Behavioural stepping unit: start with cycles=N gates N+1 cycles, then parks until en drops.
  logic        stp_running = 1'b0;
  logic        stp_stopped = 1'b0;
  logic [31:0] stp_rem = 32'd0;
  int          gated_edges = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stp_running <= 1'b0;
      stp_stopped <= 1'b0;
    end else if (!step_en) begin
      stp_running <= 1'b0;
      stp_stopped <= 1'b0;
    end else if (stp_running) begin
      gated_edges <= gated_edges + 1;
      if (stp_rem == 32'd0) begin
        stp_running <= 1'b0;
        stp_stopped <= 1'b1;
      end else begin
        stp_rem <= stp_rem - 32'd1;
      end
    end else if (step_start && !stp_stopped) begin
      stp_running <= 1'b1;
      stp_rem     <= step_cycles;
    end
  end

  clk_step_ctrl #(.FIFO_DEPTH(DEPTH), .START_TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_cycles_i(cmd_cycles), .abort_i(abort), .step_en_o(step_en),
    .step_cycles_o(step_cycles), .step_start_o(step_start), .step_running_i(stp_running),
    .busy_o(busy), .done_o(done), .err_o(err), .steps_done_o(steps_done),
    .total_cycles_o(total)
  );

  clk_step_ctrl #(.FIFO_DEPTH(DEPTH), .START_TIMEOUT(TMO), .CNT_W(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2),
    .cmd_cycles_i(cmd_cycles2), .abort_i(abort2), .step_en_o(step_en2),
    .step_cycles_o(step_cycles2), .step_start_o(step_start2), .step_running_i(1'b0),
    .busy_o(busy2), .done_o(done2), .err_o(err2), .steps_done_o(steps_done2),
    .total_cycles_o(total2)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;
  int plan_k[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    cyc++;
  endtask

  task automatic push1(input logic [31:0] k);
    cmd_valid  = 1'b1;
    cmd_cycles = k;
    nxt();
    cmd_valid  = 1'b0;
  endtask

  task automatic push2(input logic [31:0] k);
    cmd_valid2  = 1'b1;
    cmd_cycles2 = k;
    nxt();
    cmd_valid2  = 1'b0;
  endtask

  // Feeds plan_k to the main instance and checks ready/done every cycle against
  // a timeline model: a command seen by an idle controller in cycle i finishes
  // at i+1 (K=0) or i+3+K, after which the controller is idle again.
  task automatic run_plan(input string tag, input bit gappy);
    int          idx, idle_from, occ, starts, base_gated, n_ok, sum_k, e, i, k;
    int          done_q[$];
    int          pop_q[$];
    bit          exp_done, will_accept, drained;
    logic [15:0] base_steps;
    logic [47:0] base_total;
    idx = 0; idle_from = cyc; occ = 0; starts = 0; n_ok = 0; sum_k = 0; drained = 1'b0;
    base_gated = gated_edges; base_steps = steps_done; base_total = total;
    for (int n = 0; n < 600; n++) begin
      while (pop_q.size() > 0 && pop_q[0] <= cyc) begin
        void'(pop_q.pop_front());
        occ--;
      end
      chk({tag, "_ready"}, cmd_ready, (occ < DEPTH));
      exp_done = (done_q.size() > 0 && done_q[0] == cyc);
      if (exp_done) void'(done_q.pop_front());
      chk({tag, "_done"}, done, exp_done);
      if (step_start) starts++;
      if (idx == plan_k.size() && done_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
      will_accept = 1'b0;
      cmd_valid   = 1'b0;
      if (idx < plan_k.size() && (!gappy || $urandom_range(0, 3) != 0)) begin
        cmd_valid   = 1'b1;
        cmd_cycles  = plan_k[idx];
        will_accept = (occ < DEPTH);
      end
      nxt();
      if (will_accept) begin
        k = plan_k[idx];
        e = cyc;
        occ++;
        i = (e > idle_from) ? e : idle_from;
        pop_q.push_back(i + 1);
        if (k == 0) begin
          done_q.push_back(i + 1);
          idle_from = i + 1;
        end else begin
          done_q.push_back(i + 3 + k);
          idle_from = i + 4 + k;
          starts = starts - 0;
        end
        n_ok++;
        sum_k += k;
        idx++;
      end
    end
    cmd_valid = 1'b0;
    chk({tag, "_drained"}, drained, 1'b1);
    nxt();
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_steps"}, steps_done, base_steps + 16'(n_ok));
    chk({tag, "_total"}, total, base_total + 48'(sum_k));
    chk({tag, "_gated"}, gated_edges - base_gated, sum_k);
    k = 0;
    foreach (plan_k[j]) if (plan_k[j] != 0) k++;
    chk({tag, "_starts"}, starts, k);
  endtask

  int          t, g0, a;
  logic [15:0] s0;
  logic [47:0] tot0;

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_cycles = 32'd0; abort = 1'b0;
    cmd_valid2 = 1'b0; cmd_cycles2 = 32'd0; abort2 = 1'b0;
    nxt(); nxt();
    // Reset state
    chk("rst_en", step_en, 1'b0);
    chk("rst_start", step_start, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cycles", step_cycles, 32'd0);
    chk("rst_steps", steps_done, 16'd0);
    chk("rst_total", total, 48'd0);
    chk("rst_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    nxt();

    // Single step, K=3
    g0 = gated_edges;
    push1(32'd3);
    t = cyc;
    chk("s1_start_t0", step_start, 1'b0);
    nxt();
    chk("s1_start", step_start, 1'b1);
    chk("s1_en", step_en, 1'b1);
    chk("s1_cycles", step_cycles, 32'd2);
    nxt();
    chk("s1_run_first", stp_running, 1'b1);
    chk("s1_start_gone", step_start, 1'b0);
    nxt(); nxt();
    chk("s1_run_last", stp_running, 1'b1);
    nxt();
    chk("s1_run_off", stp_running, 1'b0);
    chk("s1_done_early", done, 1'b0);
    nxt();
    chk("s1_done_cycle", cyc - t, 6);
    chk("s1_done", done, 1'b1);
    chk("s1_en_rel", step_en, 1'b0);
    chk("s1_steps", steps_done, 16'd1);
    chk("s1_total", total, 48'd3);
    chk("s1_gated", gated_edges - g0, 3);
    nxt();
    chk("s1_done_pulse", done, 1'b0);
    chk("s1_busy", busy, 1'b0);

    // Queue to full: six K=1 commands pushed back to back
    plan_k = '{1, 1, 1, 1, 1, 1};
    run_plan("queue", 1'b0);

    // K=0 then K=2
    plan_k = '{0, 2};
    run_plan("k0k2", 1'b0);

    // Abort in RUN with a long step and three more queued
    push1(32'd100);
    push1(32'd5); push1(32'd5); push1(32'd5);
    nxt(); nxt(); nxt(); nxt();
    chk("ab_running", stp_running, 1'b1);
    s0 = steps_done; tot0 = total;
    abort = 1'b1;
    #1;
    chk("ab_ready_low", cmd_ready, 1'b0);
    nxt();
    chk("ab_en", step_en, 1'b0);
    chk("ab_done", done, 1'b1);
    chk("ab_err", err, 1'b1);
    abort = 1'b0;
    nxt();
    chk("ab_run_fall", stp_running, 1'b0);
    chk("ab_done_pulse", done, 1'b0);
    chk("ab_err_sticky", err, 1'b1);
    chk("ab_busy", busy, 1'b0);
    chk("ab_steps", steps_done, s0);
    chk("ab_total", total, tot0);
    nxt(); nxt();
    chk("ab_flushed", busy, 1'b0);
    push1(32'd2);
    nxt();
    chk("ab_next_start", step_start, 1'b1);
    chk("ab_err_clear", err, 1'b0);
    repeat (6) nxt();
    chk("ab_next_steps", steps_done, s0 + 16'd1);
    chk("ab_next_total", total, tot0 + 48'd2);

    // Randomized commands with random gaps
    plan_k.delete();
    for (int j = 0; j < 14; j++) plan_k.push_back($urandom_range(0, 6));
    run_plan("rand", 1'b1);

    // Start timeout on the instance whose stepper never runs
    push2(32'd3);
    nxt();
    a = cyc;
    chk("to_start", step_start2, 1'b1);
    for (int j = 1; j <= TMO + 1; j++) begin
      nxt();
      chk("to_no_done", done2, 1'b0);
    end
    nxt();
    chk("to_delay", cyc - a, TMO + 2);
    chk("to_done", done2, 1'b1);
    chk("to_err", err2, 1'b1);
    chk("to_en", step_en2, 1'b0);
    chk("to_steps", steps_done2, 3'd0);
    nxt();
    chk("to_busy", busy2, 1'b0);

    // Completed-step counter wrap (3-bit counter, K=0 commands)
    repeat (7) push2(32'd0);
    nxt();
    chk("wrap_pre", steps_done2, 3'd7);
    chk("wrap_err_kept", err2, 1'b1);
    push2(32'd0);
    nxt();
    chk("wrap", steps_done2, 3'd0);

    // Total saturation arithmetic
    chk("sat_hit", clk_step_pkg::sat_add_total(48'hFFFF_FFFF_FFFE, 33'd5), 48'hFFFF_FFFF_FFFF);
    chk("sat_max", clk_step_pkg::sat_add_total(48'hFFFF_FFFF_FFFF, 33'd1), 48'hFFFF_FFFF_FFFF);
    chk("sat_below", clk_step_pkg::sat_add_total(48'hFFFF_FFFF_FFF0, 33'd5), 48'hFFFF_FFFF_FFF5);

    // Reset asserted mid-RUN
    push1(32'd50);
    repeat (6) nxt();
    chk("mr_en_before", step_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_en", step_en, 1'b0);
    chk("mr_start", step_start, 1'b0);
    chk("mr_done", done, 1'b0);
    chk("mr_err", err, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_cycles", step_cycles, 32'd0);
    chk("mr_steps", steps_done, 16'd0);
    chk("mr_total", total, 48'd0);
    chk("mr_ready", cmd_ready, 1'b1);
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("mr_done_after", done, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
